// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- four-requester round-robin arbiter.
//
// Shares one resource between four clients. A winner is chosen in IDLE by a
// rotating-priority search that starts just after the previous owner; the
// grant is then held until the owner drops its request or the hold limit
// expires. At least one IDLE cycle separates any two grants.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   ena       : allows a new grant to be issued from IDLE (no effect in GRANT)
//   req[3:0]  : per-requester request levels
//   grant[3:0]: one-hot grant, zero when idle (decode of the registered owner)
//   grant_idx : index of the current owner, valid while busy is high
//   busy      : high while a grant is active
//   timeout   : one-cycle pulse in the IDLE cycle following a hold-limit revoke

module decoder_2_to_4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] dec
);
  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end
endmodule

module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       timeout
);
  localparam int unsigned CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] HOLD_ONE  = CW'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    last_idx;
  logic [CW-1:0] hold_cnt;

  logic [1:0]    win_idx;
  logic          win_found;

  // Rotating-priority search: candidates last_idx+1 .. last_idx+4 (mod 4),
  // so the previous owner is examined last.
  always_comb begin
    logic [1:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_idx + 2'(k);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      last_idx  <= 2'd3;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ena && win_found) begin
            grant_idx <= win_idx;
            hold_cnt  <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!req[grant_idx]) begin
            last_idx <= grant_idx;
            state    <= ST_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            last_idx <= grant_idx;
            timeout  <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_GRANT);

  decoder_2_to_4 u_dec (
    .en  (busy),
    .sel (grant_idx),
    .dec (grant)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned WAIT_MAX = 3 * (MAX_HOLD + 1) + 1;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  int checks;
  int errors;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ena;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       chk_idx;
    logic       busy;
    logic       timeout;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, then sample just after the next edge.
  task automatic step(input logic r, input logic e, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    ena = e;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic chk_idx, input logic b, input logic t);
    check({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    check({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
    check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
    if (chk_idx) check({tag, ".grant_idx"}, {6'b0, grant_idx}, {6'b0, idx});
  endtask

  initial begin
    int unsigned wait_cnt [4];
    int unsigned run;
    logic        prev_busy;
    logic [3:0]  prev_grant;
    logic [3:0]  r;
    logic        e;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    ena = 1'b0;
    req = '0;

    //          rst   ena   req      grant    idx  chk  busy  to
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    // reset priority and rotation 0,1,2,3,0
    vecs[1]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    // hold limit with req=0101: four grant cycles, timeout, then requester 2
    vecs[15] = '{1'b1, 1'b1, 4'b0101, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 4'b0101, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    // request dropped in the cycle it is granted: one grant cycle, wrap 3->0
    vecs[23] = '{1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].rst, vecs[i].ena, vecs[i].req);
      expect_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx,
                 vecs[i].chk_idx, vecs[i].busy, vecs[i].timeout);
    end

    // Enable gating: no grant while ena is low, grant one cycle after it rises,
    // and dropping ena during GRANT leaves the grant in place.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'b0010);
      expect_out($sformatf("ena_off%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 4'b0010);
    expect_out("ena_on", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 4'b0010);
      expect_out($sformatf("ena_drop%0d", i), 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 4'b0000);
    expect_out("ena_release", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-grant to requester 2, then re-arbitrate from reset priority.
    step(1'b0, 1'b1, 4'b0100);
    expect_out("mid_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b1100);
    expect_out("mid_rst", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1100);
    expect_out("post_rst", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0000);
    expect_out("post_rst_rel", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Random soak with invariant, starvation-bound and hold-length checks.
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    run = 0;
    prev_busy = 1'b0;
    prev_grant = '0;
    for (int c = 0; c < 10000; c++) begin
      r = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 15) != 0);
      step(1'b0, e, r);
      check("soak.onehot", {7'b0, ($countones(grant) <= 1)}, 8'd1);
      check("soak.grant_busy", {7'b0, (grant != 4'b0)}, {7'b0, busy});
      check("soak.to_busy", {7'b0, (timeout && busy)}, 8'd0);
      if (timeout) check("soak.hold_len", 8'(run), 8'(MAX_HOLD));
      if (busy) run = (prev_busy && grant == prev_grant) ? run + 1 : 1;
      prev_busy  = busy;
      prev_grant = grant;
      for (int i = 0; i < 4; i++) begin
        if (!e) wait_cnt[i] = 0;
        else if (r[i] && !grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > WAIT_MAX) begin
          check($sformatf("soak.wait%0d", i), 8'(wait_cnt[i]), 8'(WAIT_MAX));
          wait_cnt[i] = 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
